// File: rtl/regfile_mp.sv
// ---------------------------------------------------------------------------
// regfile_mp : parametrised multi-port register file with busy scoreboard.
//
// The register file has NREAD combinational read ports and two clocked write
// ports. Port 1 wins over port 0 when both write the same register. Each
// register also has a busy bit. A mark (producer issued) sets the bit and a
// writeback clears it, so the pipelined core can use it to detect hazards.
//
// Parameters:
//   WIDTH    data width of each register
//   DEPTH    number of registers (AW = $clog2(DEPTH) address bits)
//   NREAD    number of read ports (1..8)
//   ZERO_REG 1: register 0 reads as zero and ignores writes and marks
//
// Ports:
//   clk            rising-edge clock
//   reset          synchronous active-high reset; clears all data and busy bits
//   we0/wa0/wd0    write port 0 (enable, address, data)
//   we1/wa1/wd1    write port 1 (enable, address, data), priority over port 0
//   mark/ma        set the busy bit of register ma
//   ra             packed read addresses, port i at ra[i*AW +: AW]
//   rd             packed read data, port i at rd[i*WIDTH +: WIDTH]
//   rbusy          busy bit of the register addressed by each read port
//
// Build option:
//   REGFILE_BYPASS_EN  when defined, a valid write in the current cycle is
//                      forwarded to any read port that addresses the same
//                      register. That port then shows rbusy = 0.
// ---------------------------------------------------------------------------
module regfile_mp #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int NREAD    = 2,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   we0,
    input  logic [AW-1:0]          wa0,
    input  logic [WIDTH-1:0]       wd0,
    input  logic                   we1,
    input  logic [AW-1:0]          wa1,
    input  logic [WIDTH-1:0]       wd1,
    input  logic                   mark,
    input  logic [AW-1:0]          ma,
    input  logic [NREAD*AW-1:0]    ra,
    output logic [NREAD*WIDTH-1:0] rd,
    output logic [NREAD-1:0]       rbusy
);

    // An address is usable when it is inside the array and is not the
    // hardwired zero register.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        logic in_range;
        logic is_zero;
        in_range = (32'(a) < DEPTH);
        is_zero  = (ZERO_REG != 0) && (a == '0);
        return in_range && !is_zero;
    endfunction

    logic [WIDTH-1:0]       rf_r [DEPTH];
    logic [DEPTH-1:0]       busy_r;
    logic [DEPTH-1:0]       busy_clr_s;
    logic [DEPTH-1:0]       busy_set_s;
    logic                   wr0_ok_s;
    logic                   wr1_ok_s;
    logic                   mark_ok_s;
    logic [NREAD*WIDTH-1:0] rd_s;
    logic [NREAD-1:0]       rbusy_s;

    // Qualify writes and marks. Reset makes all of them void.
    always_comb begin
        wr0_ok_s  = !reset && we0  && addr_ok(wa0);
        wr1_ok_s  = !reset && we1  && addr_ok(wa1);
        mark_ok_s = !reset && mark && addr_ok(ma);
    end

    // Build the busy clear and set masks. The set is applied after the clear,
    // so a same-cycle mark of a written register leaves it busy.
    always_comb begin
        busy_clr_s = '0;
        busy_set_s = '0;
        for (int j = 0; j < DEPTH; j++) begin
            busy_clr_s[j] = (wr0_ok_s && (32'(wa0) == j)) ||
                            (wr1_ok_s && (32'(wa1) == j));
            busy_set_s[j] = mark_ok_s && (32'(ma) == j);
        end
    end

    // Storage and scoreboard update. Port 1 is assigned last, so it wins a
    // same-address collision.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                rf_r[k] <= '0;
            end
            busy_r <= '0;
        end else begin
            if (wr0_ok_s) begin
                rf_r[wa0] <= wd0;
            end
            if (wr1_ok_s) begin
                rf_r[wa1] <= wd1;
            end
            busy_r <= (busy_r & ~busy_clr_s) | busy_set_s;
        end
    end

    // Combinational read ports. Invalid addresses read as zero and not busy.
    always_comb begin
        logic [AW-1:0] addr_s;
        rd_s    = '0;
        rbusy_s = '0;
        for (int i = 0; i < NREAD; i++) begin
            addr_s = ra[i*AW +: AW];
            if (addr_ok(addr_s)) begin
`ifdef REGFILE_BYPASS_EN
                // A write qualifies only for a valid address, so forwarding
                // never reaches an invalid address.
                if (wr1_ok_s && (wa1 == addr_s)) begin
                    rd_s[i*WIDTH +: WIDTH] = wd1;
                    rbusy_s[i]             = 1'b0;
                end else if (wr0_ok_s && (wa0 == addr_s)) begin
                    rd_s[i*WIDTH +: WIDTH] = wd0;
                    rbusy_s[i]             = 1'b0;
                end else begin
                    rd_s[i*WIDTH +: WIDTH] = rf_r[addr_s];
                    rbusy_s[i]             = busy_r[addr_s];
                end
`else
                rd_s[i*WIDTH +: WIDTH] = rf_r[addr_s];
                rbusy_s[i]             = busy_r[addr_s];
`endif
            end else begin
                rd_s[i*WIDTH +: WIDTH] = '0;
                rbusy_s[i]             = 1'b0;
            end
        end
    end

    assign rd    = rd_s;
    assign rbusy = rbusy_s;

endmodule

// File: tb/tb_regfile_mp.sv
// ---------------------------------------------------------------------------
// tb_regfile_mp : self-checking bench for regfile_mp with default parameters
// (32 x 32, two read ports, register 0 hardwired to zero).
// In each cycle the bench computes the expected read results from its own
// reference model and pushes them to a scoreboard queue. It pops them at the
// negative edge and compares them with the DUT outputs. The model then steps
// at the posedge. Checks against fixed constants cover the key scenarios.
// ---------------------------------------------------------------------------
module tb_regfile_mp;

    logic        clk;
    logic        reset;
    logic        we0;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic        we1;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic        mark;
    logic [4:0]  ma;
    logic [9:0]  ra;
    logic [63:0] rd;
    logic [1:0]  rbusy;

    int tests_run;
    int tests_failed;

    logic [31:0] mem_m  [32];
    logic        bsy_m  [32];
    logic [32:0] sb_q   [$];
    logic [63:0] rd_seen;
    logic [1:0]  busy_seen;

    regfile_mp dut (
        .clk   (clk),
        .reset (reset),
        .we0   (we0),
        .wa0   (wa0),
        .wd0   (wd0),
        .we1   (we1),
        .wa1   (wa1),
        .wd1   (wd1),
        .mark  (mark),
        .ma    (ma),
        .ra    (ra),
        .rd    (rd),
        .rbusy (rbusy)
    );

    // Free-running clock, 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic valid_m(input logic [4:0] a);
        return a != 5'd0;
    endfunction

    function automatic logic [32:0] expect_port(input logic [4:0] a);
        logic [32:0] e;
        if (!valid_m(a)) begin
            e = 33'd0;
        end else begin
            e = {bsy_m[a], mem_m[a]};
`ifdef REGFILE_BYPASS_EN
            if (!reset && we1 && valid_m(wa1) && wa1 == a) begin
                e = {1'b0, wd1};
            end else if (!reset && we0 && valid_m(wa0) && wa0 == a) begin
                e = {1'b0, wd0};
            end
`endif
        end
        return e;
    endfunction

    // Run one cycle with the current inputs. When do_chk is set, compare
    // both read ports against the scoreboard. Then advance the model.
    task automatic step(input bit do_chk);
        logic [32:0] e;
        if (do_chk) begin
            sb_q.push_back(expect_port(ra[4:0]));
            sb_q.push_back(expect_port(ra[9:5]));
        end
        @(negedge clk);
        rd_seen   = rd;
        busy_seen = rbusy;
        if (do_chk) begin
            e = sb_q.pop_front();
            check("port0_rd", {32'd0, rd[31:0]}, {32'd0, e[31:0]});
            check("port0_busy", {63'd0, rbusy[0]}, {63'd0, e[32]});
            e = sb_q.pop_front();
            check("port1_rd", {32'd0, rd[63:32]}, {32'd0, e[31:0]});
            check("port1_busy", {63'd0, rbusy[1]}, {63'd0, e[32]});
        end
        @(posedge clk);
        if (reset) begin
            for (int k = 0; k < 32; k++) begin
                mem_m[k] = 32'd0;
                bsy_m[k] = 1'b0;
            end
        end else begin
            if (we0 && valid_m(wa0)) begin
                mem_m[wa0] = wd0;
                bsy_m[wa0] = 1'b0;
            end
            if (we1 && valid_m(wa1)) begin
                mem_m[wa1] = wd1;
                bsy_m[wa1] = 1'b0;
            end
            if (mark && valid_m(ma)) begin
                bsy_m[ma] = 1'b1;
            end
        end
        #1;
    endtask

    task automatic idle();
        reset = 1'b0; we0 = 1'b0; we1 = 1'b0; mark = 1'b0;
        wa0 = 5'd0; wa1 = 5'd0; ma = 5'd0; wd0 = 32'd0; wd1 = 32'd0;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        for (int k = 0; k < 32; k++) begin
            mem_m[k] = 32'd0;
            bsy_m[k] = 1'b0;
        end
        idle();
        ra = {5'd31, 5'd5};
        @(posedge clk);
        #1;

        // Reset, then read.
        reset = 1'b1;
        step(1'b0);
        idle();
        ra = {5'd31, 5'd5};
        step(1'b1);
        check("reset_rd", rd_seen, 64'd0);
        check("reset_busy", {62'd0, busy_seen}, 64'd0);

        // Basic write, read back in the next cycle.
        we0 = 1'b1; wa0 = 5'd3; wd0 = 32'hDEADBEEF;
        step(1'b1);
        idle();
        ra = {5'd31, 5'd3};
        step(1'b1);
        check("basic_write", {32'd0, rd_seen[31:0]}, {32'd0, 32'hDEADBEEF});

        // Writes and marks to register 0 are ignored.
        we1 = 1'b1; wa1 = 5'd0; wd1 = 32'h1234; mark = 1'b1; ma = 5'd0;
        step(1'b1);
        idle();
        ra = {5'd0, 5'd0};
        step(1'b1);
        check("zero_reg_rd", rd_seen, 64'd0);
        check("zero_reg_busy", {62'd0, busy_seen}, 64'd0);

        // Both ports write register 7; port 1 wins.
        we0 = 1'b1; wa0 = 5'd7; wd0 = 32'h11;
        we1 = 1'b1; wa1 = 5'd7; wd1 = 32'h22;
        step(1'b1);
        idle();
        ra = {5'd3, 5'd7};
        step(1'b1);
        check("collision", {32'd0, rd_seen[31:0]}, {32'd0, 32'h22});

        // Scoreboard: mark, clear by write, then mark and write together.
        mark = 1'b1; ma = 5'd9;
        step(1'b1);
        idle();
        ra = {5'd7, 5'd9};
        step(1'b1);
        check("mark_busy", {63'd0, busy_seen[0]}, 64'd1);
        we0 = 1'b1; wa0 = 5'd9; wd0 = 32'h99;
        step(1'b1);
        idle();
        step(1'b1);
        check("write_clears_busy", {63'd0, busy_seen[0]}, 64'd0);
        we0 = 1'b1; wa0 = 5'd9; wd0 = 32'h55; mark = 1'b1; ma = 5'd9;
        step(1'b1);
        idle();
        step(1'b1);
        check("mark_wins_busy", {63'd0, busy_seen[0]}, 64'd1);
        check("mark_wins_data", {32'd0, rd_seen[31:0]}, {32'd0, 32'h55});

        // Same-cycle write and read of register 4.
        we0 = 1'b1; wa0 = 5'd4; wd0 = 32'h1111;
        step(1'b1);
        idle();
        we1 = 1'b1; wa1 = 5'd4; wd1 = 32'hA5A5;
        ra = {5'd9, 5'd4};
        step(1'b1);
`ifdef REGFILE_BYPASS_EN
        check("bypass_same_cycle", {32'd0, rd_seen[31:0]}, {32'd0, 32'hA5A5});
`else
        check("no_bypass_old", {32'd0, rd_seen[31:0]}, {32'd0, 32'h1111});
`endif
        idle();
        step(1'b1);
        check("write_next_cycle", {32'd0, rd_seen[31:0]}, {32'd0, 32'hA5A5});

        // Reset in the middle of operation discards a write and a mark.
        we0 = 1'b1; wa0 = 5'd2; wd0 = 32'h2222; mark = 1'b1; ma = 5'd6;
        step(1'b1);
        idle();
        mark = 1'b1; ma = 5'd6;
        step(1'b1);
        idle();
        we0 = 1'b1; wa0 = 5'd2; wd0 = 32'h3333; mark = 1'b1; ma = 5'd6;
        reset = 1'b1;
        step(1'b1);
        idle();
        ra = {5'd6, 5'd2};
        step(1'b1);
        check("reset_mid_rd", rd_seen, 64'd0);
        check("reset_mid_busy", {62'd0, busy_seen}, 64'd0);

        // Randomised traffic checked against the model.
        for (int n = 0; n < 200; n++) begin
            reset = ($urandom_range(0, 31) == 0);
            we0   = $urandom_range(0, 1) == 1;
            we1   = $urandom_range(0, 1) == 1;
            mark  = $urandom_range(0, 2) == 0;
            wa0   = 5'($urandom_range(0, 15));
            wa1   = 5'($urandom_range(0, 15));
            ma    = 5'($urandom_range(0, 15));
            wd0   = $urandom;
            wd1   = $urandom;
            ra    = {5'($urandom_range(0, 15)), 5'($urandom_range(0, 15))};
            step(1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
